// File: rtl/alu_seq.sv
// Registered ALU with a start/done handshake. Single-cycle ops complete in one
// cycle; MUL/MULHU run an LSB-first shift-add multiply over WIDTH cycles.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALU_Ctr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res,
  output logic             Co,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned AW  = WIDTH + 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_NAND  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;
  localparam logic [3:0] OP_MULHU = 4'b1100;
  localparam logic [3:0] OP_SLT   = 4'b1101;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic             mul_hi;
  logic [SHW-1:0]   cnt;

  logic             sub_c;
  logic [WIDTH-1:0] b_add_c;
  logic [WIDTH-1:0] sum_c;
  logic             co_add_c;
  logic             ov_add_c;
  logic [SHW-1:0]   shamt_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_co_c;
  logic             alu_ov_c;
  logic             is_mul_c;
  logic [PW-1:0]    acc_nxt_c;
  logic [WIDTH-1:0] mul_res_c;

  // Shared adder: SUB is A + ~B + 1, so carry-out 1 means no borrow.
  always_comb begin
    sub_c               = (ALU_Ctr == OP_SUB);
    b_add_c             = sub_c ? ~B : B;
    {co_add_c, sum_c}   = {1'b0, A} + {1'b0, b_add_c} + AW'(sub_c);
    ov_add_c            = (A[WIDTH-1] == b_add_c[WIDTH-1]) && (sum_c[WIDTH-1] != A[WIDTH-1]);
    shamt_c             = B[SHW-1:0];
    is_mul_c            = (ALU_Ctr == OP_MUL) || (ALU_Ctr == OP_MULHU);
  end

  // Single-cycle result and flags; reserved opcodes fall through to zero.
  always_comb begin
    alu_res_c = '0;
    alu_co_c  = 1'b0;
    alu_ov_c  = 1'b0;
    case (ALU_Ctr)
      OP_AND:  alu_res_c = A & B;
      OP_OR:   alu_res_c = A | B;
      OP_XOR:  alu_res_c = A ^ B;
      OP_NOR:  alu_res_c = ~(A | B);
      OP_NAND: alu_res_c = ~(A & B);
      OP_ADD, OP_SUB: begin
        alu_res_c = sum_c;
        alu_co_c  = co_add_c;
        alu_ov_c  = ov_add_c;
      end
      OP_SLTU: alu_res_c = WIDTH'(A < B);
      OP_SLT:  alu_res_c = WIDTH'($signed(A) < $signed(B));
      OP_SLL:  alu_res_c = A << shamt_c;
      OP_SRL:  alu_res_c = A >> shamt_c;
      OP_SRA:  alu_res_c = WIDTH'($signed(A) >>> shamt_c);
      default: alu_res_c = '0;
    endcase
  end

  // One shift-add step; the final step's sum is what gets written back.
  always_comb begin
    acc_nxt_c = acc + (mplier[0] ? mcand : '0);
    mul_res_c = mul_hi ? acc_nxt_c[PW-1:WIDTH] : acc_nxt_c[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      res      <= '0;
      Co       <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      mul_hi   <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul_c) begin
              mcand  <= PW'(A);
              mplier <= B;
              mul_hi <= (ALU_Ctr == OP_MULHU);
              acc    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= MUL;
            end else begin
              res      <= alu_res_c;
              Co       <= alu_co_c;
              overflow <= alu_ov_c;
              zero     <= (alu_res_c == '0);
              done     <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_nxt_c;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH - 1)) begin
            res      <= mul_res_c;
            Co       <= 1'b0;
            overflow <= 1'b0;
            zero     <= (mul_res_c == '0);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32: inputs driven and outputs sampled on
// the falling edge, expected values hand-computed.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  ALU_Ctr;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] res;
  logic        Co;
  logic        zero;
  logic        overflow;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int busy_n = 0;
  int done_n = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ALU_Ctr(ALU_Ctr), .A(A), .B(B),
    .res(res), .Co(Co), .zero(zero), .overflow(overflow), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge: present one request for a single cycle.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    ALU_Ctr = op;
    A       = a;
    B       = b;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic flags(input string tag, input logic [31:0] r, input logic z,
                       input logic c, input logic v);
    chk({tag, "_res"},  res, r);
    chk({tag, "_zero"}, 32'(zero), 32'(z));
    chk({tag, "_co"},   32'(Co), 32'(c));
    chk({tag, "_ov"},   32'(overflow), 32'(v));
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Waits (bounded) for done, counting falling edges since the multiply was accepted.
  task automatic wait_done();
    while (!done && cyc < 100) begin
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ALU_Ctr = 4'h0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst_res", res, 32'h0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    drive(4'b0010, 32'hFFFF_FFFF, 32'h1);
    flags("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("add_done_pulse", 32'(done), 32'd0);

    drive(4'b0110, 32'h8000_0000, 32'h1);
    flags("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    drive(4'b0110, 32'h1, 32'h2);
    flags("sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    drive(4'b1101, 32'hFFFF_FFFF, 32'h0);
    flags("slt", 32'h1, 1'b0, 1'b0, 1'b0);
    drive(4'b0111, 32'hFFFF_FFFF, 32'h0);
    flags("sltu", 32'h0, 1'b1, 1'b0, 1'b0);
    drive(4'b1010, 32'h8000_0000, 32'h24);
    flags("sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0);
    drive(4'b1001, 32'h8000_0000, 32'h24);
    flags("srl", 32'h0800_0000, 1'b0, 1'b0, 1'b0);
    drive(4'b1000, 32'h1, 32'd31);
    flags("sll", 32'h8000_0000, 1'b0, 1'b0, 1'b0);

    // Back-to-back single-cycle ops: done stays high, one pulse per op.
    start = 1'b1; ALU_Ctr = 4'b0010; A = 32'h7FFF_FFFF; B = 32'h1;
    @(negedge clk);
    flags("b2b_add", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    ALU_Ctr = 4'b0011; A = 32'h0F0F_0F0F; B = 32'hFFFF_0000;
    @(negedge clk);
    start = 1'b0;
    flags("b2b_xor", 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 32'h0000_FFFF, 32'h00FF_0000);
    flags("or", 32'h00FF_FFFF, 1'b0, 1'b0, 1'b0);
    drive(4'b0100, 32'h0, 32'h0);
    flags("nor", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    drive(4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    flags("nand", 32'h0, 1'b1, 1'b0, 1'b0);
    drive(4'b1110, 32'h5, 32'h5);
    flags("rsvd", 32'h0, 1'b1, 1'b0, 1'b0);

    // Multiplies: latency and busy span are both WIDTH cycles.
    cyc = 1; busy_n = 0;
    drive(4'b1011, 32'h0001_0000, 32'h0001_0000);
    wait_done();
    chk("mul_latency", 32'(cyc - 1), 32'd32);
    chk("mul_busy_cycles", 32'(busy_n), 32'd32);
    chk("mul_busy_at_done", 32'(busy), 32'd0);
    flags("mul_lo", 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("mul_done_pulse", 32'(done), 32'd0);

    cyc = 1;
    drive(4'b1100, 32'h0001_0000, 32'h0001_0000);
    wait_done();
    chk("mulhu_latency", 32'(cyc - 1), 32'd32);
    flags("mulhu", 32'h1, 1'b0, 1'b0, 1'b0);
    cyc = 1;
    drive(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    flags("mul_ff", 32'h1, 1'b0, 1'b0, 1'b0);
    cyc = 1;
    drive(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    flags("mulhu_ff", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

    // A start while busy is ignored; a start on the done cycle is accepted.
    cyc = 1;
    drive(4'b1011, 32'h3, 32'h5);
    repeat (4) begin
      @(negedge clk);
      cyc++;
    end
    drive(4'b0010, 32'h1, 32'h1);
    cyc++;
    chk("ignored_done", 32'(done), 32'd0);
    chk("ignored_busy", 32'(busy), 32'd1);
    chk("ignored_res", res, 32'hFFFF_FFFE);
    wait_done();
    chk("mul_int_latency", 32'(cyc - 1), 32'd32);
    flags("mul_int", 32'hF, 1'b0, 1'b0, 1'b0);
    drive(4'b0010, 32'h2, 32'h3);
    flags("add_after_mul", 32'h5, 1'b0, 1'b0, 1'b0);

    // Reset mid-multiply, with a simultaneous start that reset must win over.
    drive(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (8) @(negedge clk);
    rst = 1'b1; start = 1'b1; ALU_Ctr = 4'b0010; A = 32'h1; B = 32'h1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_res", res, 32'h0);
    chk("mrst_zero", 32'(zero), 32'd1);
    chk("mrst_done", 32'(done), 32'd0);
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("mrst_no_done", 32'(done_n), 32'd0);
    drive(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    flags("and", 32'hF000_F000, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
